// File: rtl/adder_share_ctrl_if.sv
// Bundle of requester-side signals for the shared 32-bit adder controller.
// The requester cluster is the master. The controller is the slave.
interface adder_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    op_sub;
  logic [32*N_REQ-1:0] a_in;
  logic [32*N_REQ-1:0] b_in;
  logic [N_REQ-1:0]    gnt;
  logic                busy;
  logic                done;
  logic [ID_W-1:0]     done_id;
  logic [31:0]         result;
  logic                carry;
  logic                ovf;
  logic                zero;

  modport master (
    output req, op_sub, a_in, b_in,
    input  gnt, busy, done, done_id, result, carry, ovf, zero
  );

  modport slave (
    input  req, op_sub, a_in, b_in,
    output gnt, busy, done, done_id, result, carry, ovf, zero
  );
endinterface

// File: rtl/adder_share_ctrl.sv
// Round-robin time-sharing of one 32-bit hybrid carry-lookahead adder among N_REQ requesters.
// Each operation takes 3 cycles: grant/capture, execute, respond.
module hybrid_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g, p;
  logic [32:0] c;
  int          base;

  // 4-bit lookahead groups; the group carries ripple from group to group
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    base = 0;
    for (int grp = 0; grp < 8; grp++) begin
      base = 4 * grp;
      c[base+1] = g[base] | (p[base] & c[base]);
      c[base+2] = g[base+1] | (p[base+1] & g[base]) | (p[base+1] & p[base] & c[base]);
      c[base+3] = g[base+2] | (p[base+2] & g[base+1]) | (p[base+2] & p[base+1] & g[base])
                | (p[base+2] & p[base+1] & p[base] & c[base]);
      c[base+4] = g[base+3] | (p[base+3] & g[base+2]) | (p[base+3] & p[base+2] & g[base+1])
                | (p[base+3] & p[base+2] & p[base+1] & g[base])
                | (p[base+3] & p[base+2] & p[base+1] & p[base] & c[base]);
    end
    sum  = p ^ c[31:0];
    cout = c[32];
  end
endmodule

module adder_share_ctrl #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  adder_share_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic              sub_q, sub_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic [31:0]       result_q, result_d;
  logic              carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [ID_W-1:0]   win_id;
  logic              win_found;
  int                idx;

  logic [31:0]       b_eff, sum;
  logic              cout;

  // Subtraction is a + ~b + 1, so carry out means "no borrow"
  assign b_eff = sub_q ? ~b_q : b_q;

  hybrid_adder u_adder (
    .a    (a_q),
    .b    (b_eff),
    .cin  (sub_q),
    .sum  (sum),
    .cout (cout)
  );

  // First set request at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // NOTE: every variable gets its hold value first, so no path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    done_id_d = done_id_q;
    result_d  = result_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_found) begin
          id_d          = win_id;
          a_d           = bus.a_in[32*int'(win_id) +: 32];
          b_d           = bus.b_in[32*int'(win_id) +: 32];
          sub_d         = bus.op_sub[win_id];
          gnt_d[win_id] = 1'b1;
          busy_d        = 1'b1;
          state_d       = EXEC;
        end
      end
      EXEC: begin
        result_d  = sum;
        carry_d   = cout;
        ovf_d     = (a_q[31] == b_eff[31]) && (sum[31] != a_q[31]);
        zero_d    = (sum == 32'd0);
        done_id_d = id_q;
        done_d    = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        done_d   = 1'b0;
        gnt_d    = '0;
        busy_d   = 1'b0;
        rr_ptr_d = (int'(id_q) == N_REQ - 1) ? '0 : ID_W'(int'(id_q) + 1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
    end
  end

  // NOTE: operand registers carry no reset; they are always written in IDLE before EXEC reads them.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sub_q <= sub_d;
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.result  = result_q;
  assign bus.carry   = carry_q;
  assign bus.ovf     = ovf_q;
  assign bus.zero    = zero_q;
endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed and randomized checks of adder_share_ctrl against a transaction-level
// reference model that uses plain arithmetic.
module tb_adder_share_ctrl;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_share_ctrl_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  adder_share_ctrl #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: phase counts cycles into the current operation
  int          m_phase = 0;
  int          m_ptr   = 0;
  int          m_id    = 0;
  logic [31:0] m_a, m_b;
  logic        m_sub;
  logic [N_REQ-1:0] exp_gnt = '0;
  logic        exp_busy = 0, exp_done = 0, exp_carry = 0, exp_ovf = 0, exp_zero = 0;
  logic [31:0] exp_result = '0;
  int          exp_done_id = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         output logic [31:0] r, output logic c, output logic v, output logic z);
    longint sa, sb, ideal;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r     = a - b;
      c     = (a >= b);
      ideal = sa - sb;
    end else begin
      r     = a + b;
      c     = ({1'b0, a} + {1'b0, b}) > 33'h0FFFF_FFFF;
      ideal = sa + sb;
    end
    v = (ideal > 64'sd2147483647) || (ideal < -64'sd2147483648);
    z = (r == 32'd0);
  endtask

  task automatic model_edge();
    if (rst) begin
      m_phase = 0; m_ptr = 0;
      exp_gnt = '0; exp_busy = 0; exp_done = 0; exp_done_id = 0;
      exp_result = '0; exp_carry = 0; exp_ovf = 0; exp_zero = 0;
    end else if (m_phase == 0) begin
      exp_gnt = '0;
      if (bus.req != 0) begin
        for (int k = 0; k < N_REQ; k++) begin
          if (bus.req[(m_ptr + k) % N_REQ]) begin
            m_id = (m_ptr + k) % N_REQ;
            break;
          end
        end
        m_a      = bus.a_in[32*m_id +: 32];
        m_b      = bus.b_in[32*m_id +: 32];
        m_sub    = bus.op_sub[m_id];
        exp_gnt  = N_REQ'(1) << m_id;
        exp_busy = 1;
        m_phase  = 1;
      end
    end else if (m_phase == 1) begin
      ref_alu(m_a, m_b, m_sub, exp_result, exp_carry, exp_ovf, exp_zero);
      exp_done    = 1;
      exp_done_id = m_id;
      m_phase     = 2;
    end else begin
      exp_done = 0; exp_gnt = '0; exp_busy = 0;
      m_ptr    = (m_id + 1) % N_REQ;
      m_phase  = 0;
    end
  endtask

  // One clock: the model consumes the inputs present at the edge, then outputs are compared 1 ns later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("gnt", bus.gnt, exp_gnt);
    check("busy", bus.busy, exp_busy);
    check("done", bus.done, exp_done);
    check("done_id", bus.done_id, exp_done_id);
    check("result", bus.result, exp_result);
    check("carry", bus.carry, exp_carry);
    check("ovf", bus.ovf, exp_ovf);
    check("zero", bus.zero, exp_zero);
  endtask

  task automatic set_port(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub);
    bus.a_in[32*i +: 32] = a;
    bus.b_in[32*i +: 32] = b;
    bus.op_sub[i]        = sub;
  endtask

  // Single operation on a lone port: request, drop after grant, step through E1 and E2
  task automatic single_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub);
    set_port(i, a, b, sub);
    bus.req = N_REQ'(1) << i;
    step();
    check("op_gnt", bus.gnt, 32'(1) << i);
    bus.req = '0;
    step();
    check("op_done", bus.done, 1);
    check("op_done_id", bus.done_id, i);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(5))
      0: rand_operand = 32'h0000_0000;
      1: rand_operand = 32'h0000_0001;
      2: rand_operand = 32'hFFFF_FFFF;
      3: rand_operand = 32'h7FFF_FFFF;
      4: rand_operand = 32'h8000_0000;
      default: rand_operand = $urandom;
    endcase
  endfunction

  initial begin
    int gnt_cnt, last_cyc, cur_id;
    int order [5];
    order = '{0, 1, 2, 3, 0};

    bus.req = '0; bus.op_sub = '0; bus.a_in = '0; bus.b_in = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_gnt", bus.gnt, 0);

    // 1: 5 + 7 on port 0
    single_op(0, 32'd5, 32'd7, 1'b0);
    check("t1_result", bus.result, 32'd12);
    check("t1_flags", {bus.carry, bus.ovf, bus.zero}, 3'b000);
    step();
    check("t1_idle", bus.busy, 0);

    // 2: port 2 subtractions
    single_op(2, 32'd3, 32'd3, 1'b1);
    check("t2_result", bus.result, 32'd0);
    check("t2_zc", {bus.zero, bus.carry}, 2'b11);
    step();
    single_op(2, 32'd0, 32'd1, 1'b1);
    check("t2b_result", bus.result, 32'hFFFF_FFFF);
    check("t2b_carry", bus.carry, 0);
    step();

    // 3: overflow and wrap on port 1
    single_op(1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    check("t3_result", bus.result, 32'h8000_0000);
    check("t3_ovc", {bus.ovf, bus.carry}, 2'b10);
    step();
    single_op(1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check("t3b_result", bus.result, 32'd0);
    check("t3b_cvz", {bus.carry, bus.ovf, bus.zero}, 3'b101);
    step();

    // 4: all ports held from reset; round-robin order, 3-cycle grant spacing
    for (int i = 0; i < N_REQ; i++) set_port(i, 32'(i * 100), 32'(i), 1'b0);
    bus.req = '1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    gnt_cnt = 0; last_cyc = 0; cur_id = 0;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      logic [N_REQ-1:0] prev_gnt;
      prev_gnt = bus.gnt;
      step();
      if (bus.gnt != 0 && prev_gnt == 0 && gnt_cnt < 5) begin
        for (int i = 0; i < N_REQ; i++) if (bus.gnt[i]) cur_id = i;
        check("t4_order", cur_id, order[gnt_cnt]);
        if (gnt_cnt > 0) check("t4_spacing", cyc - last_cyc, 3);
        last_cyc = cyc;
        gnt_cnt++;
      end
      if (bus.done) check("t4_done_id", bus.done_id, cur_id);
    end
    check("t4_count", gnt_cnt, 5);
    bus.req = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;

    // 5: operands change right after grant must not disturb the captured ones
    set_port(0, 32'd10, 32'd1, 1'b0);
    bus.req = 4'b0001;
    step();
    check("t5_gnt", bus.gnt, 1);
    bus.req = '0;
    set_port(0, 32'd99, 32'd1, 1'b0);
    step();
    check("t5_result", bus.result, 32'd11);
    step();

    // 6: reset during EXEC drops the operation; port 2 then wins from rr_ptr=0
    set_port(1, 32'd4, 32'd4, 1'b0);
    bus.req = 4'b0010;
    step();
    bus.req = '0;
    rst = 1'b1;
    step();
    check("t6_done", bus.done, 0);
    check("t6_result", bus.result, 0);
    rst = 1'b0;
    set_port(2, 32'd8, 32'd2, 1'b1);
    bus.req = 4'b0100;
    step();
    check("t6_gnt", bus.gnt, 32'b0100);
    check("t6_no_done", bus.done, 0);
    bus.req = '0;
    step();
    check("t6_result2", bus.result, 32'd6);
    step();

    // Random traffic: requesters hold until granted, sometimes re-request, rare resets
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req[i] && bus.gnt[i]) begin
          if ($urandom_range(3) != 0) bus.req[i] = 1'b0;
          set_port(i, rand_operand(), rand_operand(), 1'($urandom_range(1)));
        end else if (!bus.req[i] && $urandom_range(2) == 0) begin
          set_port(i, rand_operand(), rand_operand(), 1'($urandom_range(1)));
          bus.req[i] = 1'b1;
        end
      end
      rst = ($urandom_range(79) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
